// File: rtl/frame_scheduler.sv
// ============================================================================
// Module   : frame_scheduler
// Purpose  : Steps through a programmable 8-entry frame table and emits the
//            f_sync/sync pulses that drive a pattern engine. Optional macro
//            FRAME_SCHEDULER_FRAME_CNT_EN adds the completed-frame counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module frame_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [22:0] wr_data,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  input  logic [2:0]  num_entries,
  input  logic [4:0]  frame_lines,
  input  logic        line_done,
  output logic        f_sync,
  output logic        sync,
  output logic [2:0]  mode,
  output logic [1:0]  x,
  output logic [1:0]  y,
  output logic [11:0] const_val,
  output logic        busy,
  output logic        done,
  output logic [2:0]  entry_idx,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_FSYNC      = 3'd2,
    S_LINE_START = 3'd3,
    S_LINE_WAIT  = 3'd4,
    S_FRAME_END  = 3'd5
  } state_t;

  state_t      state_q;
  logic [22:0] table_q [8];
  logic [22:0] entry_w;
  logic        f_sync_q, sync_q, busy_q, done_q, stop_pend_q;
  logic [2:0]  mode_q, entry_idx_q;
  logic [1:0]  x_q, y_q;
  logic [11:0] const_q;
  logic [3:0]  rep_q;
  logic [5:0]  line_cnt_q, line_cnt_d, lines_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) table_q[i] <= '0;
    end else if (wr_en) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  assign entry_w      = table_q[entry_idx_q];
  assign line_cnt_d   = line_cnt_q + 6'd1;
  // A programmed line count of zero stands for the full 32-line frame.
  assign lines_target = (frame_lines == 5'd0) ? 6'd32 : {1'b0, frame_lines};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      f_sync_q    <= 1'b0;
      sync_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      mode_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      const_q     <= '0;
      entry_idx_q <= '0;
      rep_q       <= '0;
      line_cnt_q  <= '0;
    end else begin
      f_sync_q <= 1'b0;
      sync_q   <= 1'b0;
      done_q   <= 1'b0;
      if (stop && (state_q != S_IDLE)) stop_pend_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_LOAD;
            entry_idx_q <= '0;
            busy_q      <= 1'b1;
          end
        end
        S_LOAD: begin
          mode_q   <= entry_w[2:0];
          x_q      <= entry_w[4:3];
          y_q      <= entry_w[6:5];
          const_q  <= entry_w[18:7];
          rep_q    <= entry_w[22:19];
          f_sync_q <= 1'b1;
          state_q  <= S_FSYNC;
        end
        S_FSYNC: begin
          line_cnt_q <= '0;
          sync_q     <= 1'b1;
          state_q    <= S_LINE_START;
        end
        S_LINE_START: begin
          state_q <= S_LINE_WAIT;
        end
        S_LINE_WAIT: begin
          if (line_done) begin
            line_cnt_q <= line_cnt_d;
            if (line_cnt_d == lines_target) begin
              state_q <= S_FRAME_END;
            end else begin
              sync_q  <= 1'b1;
              state_q <= S_LINE_START;
            end
          end
        end
        S_FRAME_END: begin
          if (stop_pend_q) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            stop_pend_q <= 1'b0;
          end else if (rep_q != 4'd0) begin
            rep_q    <= rep_q - 4'd1;
            f_sync_q <= 1'b1;
            state_q  <= S_FSYNC;
          end else if (entry_idx_q < num_entries) begin
            entry_idx_q <= entry_idx_q + 3'd1;
            state_q     <= S_LOAD;
          end else if (loop_en) begin
            entry_idx_q <= '0;
            state_q     <= S_LOAD;
          end else begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            stop_pend_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FRAME_SCHEDULER_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = (frame_cnt_q == 16'hFFFF) ? frame_cnt_q : frame_cnt_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      frame_cnt_q <= '0;
    end else if (state_q == S_FRAME_END) begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'd0;
`endif

  assign f_sync    = f_sync_q;
  assign sync      = sync_q;
  assign mode      = mode_q;
  assign x         = x_q;
  assign y         = y_q;
  assign const_val = const_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign entry_idx = entry_idx_q;

endmodule

`default_nettype wire

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Ports SHALL be, one per line (name, direction, width, meaning), clock and reset first:
  clk  in  1  master clock; all logic on rising edge
  rst  in  1  synchronous, active-high reset
  wr_en  in  1  program-table write strobe
  wr_addr  in  3  table entry index
  wr_data  in  23  {repeat[22:19], const_val[18:7], y[6:5], x[4:3], mode[2:0]}
  start  in  1  one-cycle pulse; begins program at entry 0
  stop  in  1  one-cycle pulse; graceful halt request
  loop_en  in  1  1 = wrap to entry 0 after last entry
  num_entries  in  3  active entries = num_entries+1
  frame_lines  in  5  lines per frame; 0 means 32
  line_done  in  1  one-cycle pulse from pattern engine at end of line
  f_sync  out  1  first-sync pulse to pattern engine
  sync  out  1  line-start pulse to pattern engine
  mode  out  3  pattern mode for current frame
  x  out  2  ramp deltaX
  y  out  2  ramp deltaY
  const_val  out  12  constant value
  busy  out  1  high outside IDLE
  done  out  1  one-cycle pulse on program completion or stop
  entry_idx  out  3  currently active entry
  frame_cnt  out  16  frames completed since start
REQ-002 Reset SHALL be synchronous and active-high on rst; single clock clk.

Function
REQ-003 Table SHALL be 8 x 23-bit registers, written on wr_en at any time; a write to the active entry SHALL take effect at its next LOAD.
REQ-004 FSM states SHALL be IDLE, LOAD, FSYNC, LINE_START, LINE_WAIT, FRAME_END.
REQ-005 IDLE: start -> LOAD with entry_idx=0, repeat counter loaded from entry 0; start SHALL be ignored outside IDLE.
REQ-006 LOAD (1 cycle): mode/x/y/const_val SHALL register from table[entry_idx]; -> FSYNC. Outputs SHALL stay constant until the next LOAD.
REQ-007 FSYNC: f_sync=1 for exactly this cycle; line counter cleared; -> LINE_START.
REQ-008 LINE_START: sync=1 for exactly this cycle; -> LINE_WAIT.
REQ-009 LINE_WAIT: on line_done increment line counter; if count == frame_lines (32 when 0) -> FRAME_END, else -> LINE_START. line_done in any other state SHALL be ignored.
REQ-010 FRAME_END (1 cycle): frame_cnt increments (saturates at 0xFFFF). Priority: stop_pending -> IDLE with done; else repeat counter nonzero -> decrement, -> FSYNC (same params); else entry_idx < num_entries -> entry_idx+1, -> LOAD; else loop_en -> entry_idx=0, -> LOAD; else -> IDLE with done.
REQ-011 Repeat field r SHALL yield exactly r+1 consecutive frames of that entry.
REQ-012 stop SHALL set stop_pending; the current frame SHALL complete; stop_pending clears on entry to IDLE. stop in IDLE SHALL be ignored.
REQ-013 stop and line_done in the same cycle SHALL both be honoured.
REQ-014 Latency: start at cycle t -> LOAD t+1, params valid and f_sync=1 at t+2, sync=1 at t+3.
REQ-015 done SHALL be a one-cycle pulse coincident with the FRAME_END->IDLE transition output cycle.
REQ-016 busy SHALL be 0 only in IDLE.
REQ-017 frame_cnt SHALL clear on start.

Reset
REQ-018 On rst: state IDLE; f_sync, sync, busy, done = 0; mode, x, y, const_val, entry_idx = 0; frame_cnt = 0; stop_pending = 0; table contents = 0.
REQ-019 rst mid-frame SHALL abort with no done pulse; outputs reach reset values after the first rising edge with rst=1.

Configuration
REQ-020 Macro FRAME_SCHEDULER_FRAME_CNT_EN: defined -> frame_cnt counter implemented per REQ-010/017; undefined -> counter logic absent, frame_cnt tied to 0, all other behaviour unchanged.

Verification
REQ-021 Program entry0 {mode=1, const=0xABC, rep=0}, num_entries=0, frame_lines=2, loop_en=0, start -> f_sync at t+2, sync at t+3, 2 syncs total, done after 2nd line_done, frame_cnt=1.
REQ-022 Entries 0..2 rep=1, num_entries=2, frame_lines=1 -> 6 f_sync pulses, entry_idx sequence 0,0,1,1,2,2, mode changes only after LOAD, done once.
REQ-023 loop_en=1, num_entries=1, stop pulse mid 3rd frame -> 3rd frame finishes (all lines), IDLE, done=1, entry_idx=0.
REQ-024 frame_lines=0 -> exactly 32 sync pulses per f_sync; spurious line_done in FSYNC/LINE_START ignored.
REQ-025 rst asserted in LINE_WAIT -> next cycle all outputs at reset values, no done; subsequent start runs normally.
REQ-026 With macro undefined, run REQ-021 -> identical f_sync/sync/done timing, frame_cnt=0 throughout.
